// File: rtl/step_sequencer.sv
// Execution sequencer: turns run/step/halt button pulses into the core's one-cycle step strobe.
// Breakpoint logic is built only when STEP_SEQUENCER_BREAKPOINT_EN is defined.
module step_sequencer #(
    parameter int unsigned DIV    = 50000000,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              step,
    input  logic              halt,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_valid,
    output logic              cpu_en,
    output logic              running,
    output logic              bp_hit,
    output logic [15:0]       instr_count
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam logic [31:0] DIV_M1 = 32'(DIV - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] instr_count_q;
    logic        due;
    logic        bp_stop;

`ifdef STEP_SEQUENCER_BREAKPOINT_EN
    logic skip_q, skip_d;
    logic bp_hit_q, bp_hit_d;
`else
    logic unused_bp;
    assign unused_bp = ^{bp_addr, bp_valid, pc};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        due     = 1'b0;
        bp_stop = 1'b0;
        cpu_en  = 1'b0;
`ifdef STEP_SEQUENCER_BREAKPOINT_EN
        skip_d   = skip_q;
        bp_hit_d = bp_hit_q;
`endif
        case (state_q)
            ST_HALT: begin
                if (run) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
`ifdef STEP_SEQUENCER_BREAKPOINT_EN
                    skip_d   = 1'b1;
                    bp_hit_d = 1'b0;
`endif
                end else if (step) begin
                    state_d = ST_STEP;
`ifdef STEP_SEQUENCER_BREAKPOINT_EN
                    bp_hit_d = 1'b0;
`endif
                end
            end
            ST_STEP: begin
                cpu_en  = 1'b1;
                state_d = ST_HALT;
            end
            ST_RUN: begin
                due   = (cnt_q == DIV_M1);
                cnt_d = due ? '0 : cnt_q + 32'd1;
`ifdef STEP_SEQUENCER_BREAKPOINT_EN
                // skip lets a resume from the breakpoint address execute that instruction
                bp_stop = due && !skip_q && bp_valid && (pc == bp_addr);
`endif
                cpu_en = due && !bp_stop;
`ifdef STEP_SEQUENCER_BREAKPOINT_EN
                if (cpu_en) begin
                    skip_d = 1'b0;
                end
                if (bp_stop) begin
                    bp_hit_d = 1'b1;
                end
`endif
                if (bp_stop || halt) begin
                    state_d = ST_HALT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_HALT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HALT;
            cnt_q         <= '0;
            instr_count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cpu_en) begin
                instr_count_q <= instr_count_q + 16'd1;
            end
        end
    end

`ifdef STEP_SEQUENCER_BREAKPOINT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_q   <= 1'b0;
            bp_hit_q <= 1'b0;
        end else begin
            skip_q   <= skip_d;
            bp_hit_q <= bp_hit_d;
        end
    end
    assign bp_hit = bp_hit_q;
`else
    assign bp_hit = 1'b0;
`endif

    assign running     = (state_q == ST_RUN);
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Randomised and directed checks of step_sequencer against an event-based reference model.
module tb_step_sequencer;

    localparam int unsigned DIV = 4;
    localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0, step = 1'b0, halt = 1'b0;
    logic [3:0]  pc = 4'd0, bp_addr = 4'd0;
    logic        bp_valid = 1'b0;
    logic        cpu_en, running, bp_hit;
    logic [15:0] instr_count;

    // second instance with DIV=1 for the every-cycle strobe and counter wrap
    logic        run2 = 1'b0, halt2 = 1'b0, step2 = 1'b0, bp_valid2 = 1'b0;
    logic [3:0]  pc2 = 4'd0, bp_addr2 = 4'd0;
    logic        cpu_en2, running2, bp_hit2;
    logic [15:0] instr_count2;

    step_sequencer #(.DIV(DIV), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halt(halt),
        .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
        .cpu_en(cpu_en), .running(running), .bp_hit(bp_hit), .instr_count(instr_count)
    );

    step_sequencer #(.DIV(1), .ADDR_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .run(run2), .step(step2), .halt(halt2),
        .pc(pc2), .bp_addr(bp_addr2), .bp_valid(bp_valid2),
        .cpu_en(cpu_en2), .running(running2), .bp_hit(bp_hit2), .instr_count(instr_count2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // reference model: mode plus the cycle at which the current run was accepted
    int          m_mode  = M_HALT;
    longint      m_cyc   = 0;
    longint      m_start = 0;
    bit          m_bp_hit = 1'b0;
    logic [15:0] m_count = 16'd0;
    bit          m_en;

    // one clock cycle; entered and left at posedge+1
    task automatic tick(input bit r, input bit s, input bit h);
        longint elapsed;
        bit     due, stop;
        run = r; step = s; halt = h;
        @(negedge clk);
        m_en = 1'b0; stop = 1'b0;
        if (m_mode == M_STEP) m_en = 1'b1;
        if (m_mode == M_RUN) begin
            elapsed = m_cyc - m_start;
            due     = (elapsed % DIV) == 0;
`ifdef STEP_SEQUENCER_BREAKPOINT_EN
            stop = due && (elapsed != DIV) && bp_valid && (pc == bp_addr);
`endif
            m_en = due && !stop;
        end
        check_val("cpu_en", {31'd0, cpu_en}, {31'd0, m_en});
        check_val("running", {31'd0, running}, {31'd0, m_mode == M_RUN});
        check_val("bp_hit", {31'd0, bp_hit}, {31'd0, m_bp_hit});
        check_val("instr_count", {16'd0, instr_count}, {16'd0, m_count});
        case (m_mode)
            M_HALT: begin
                if (r) begin
                    m_mode = M_RUN; m_start = m_cyc; m_bp_hit = 1'b0;
                end else if (s) begin
                    m_mode = M_STEP; m_bp_hit = 1'b0;
                end
            end
            M_STEP: m_mode = M_HALT;
            default: begin
                if (stop) begin
                    m_mode = M_HALT; m_bp_hit = 1'b1;
                end else if (h) begin
                    m_mode = M_HALT;
                end
            end
        endcase
        if (m_en) m_count = m_count + 16'd1;
        @(posedge clk);
        #1;
        if (m_en) pc = pc + 4'd1;
        run = 1'b0; step = 1'b0; halt = 1'b0;
        m_cyc++;
    endtask

    task automatic async_reset();
        #1 rst_n = 1'b0;
        #1;
        check_val("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        check_val("rst_running", {31'd0, running}, 32'd0);
        check_val("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
        check_val("rst_count", {16'd0, instr_count}, 32'd0);
        m_mode = M_HALT; m_bp_hit = 1'b0; m_count = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] base;
        #1;
        check_val("por_count", {16'd0, instr_count}, 32'd0);
        check_val("por_running", {31'd0, running}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        repeat (20) tick(0, 0, 0);

        // run, three strobes, halt on a non-due cycle
        tick(1, 0, 0);
        repeat (12) tick(0, 0, 0);
        tick(0, 0, 1);
        repeat (5) tick(0, 0, 0);
        check_val("count_after_run", {16'd0, instr_count}, 32'd3);

        // single steps, then run and step together
        repeat (3) begin
            tick(0, 1, 0);
            repeat (4) tick(0, 0, 0);
        end
        check_val("count_after_steps", {16'd0, instr_count}, 32'd6);
        tick(1, 1, 0);
        repeat (3) tick(0, 0, 0);
        tick(0, 0, 1);
        tick(0, 0, 0);

        // breakpoint stop and resume
        pc = 4'd0; bp_valid = 1'b1; bp_addr = 4'd5;
        base = m_count;
        tick(1, 0, 0);
        for (int i = 0; i < 60 && m_mode == M_RUN; i++) tick(0, 0, 0);
`ifdef STEP_SEQUENCER_BREAKPOINT_EN
        check_val("bp_strobes", {16'd0, instr_count - base}, 32'd5);
        check_val("bp_hit_set", {31'd0, bp_hit}, 32'd1);
        check_val("bp_running", {31'd0, running}, 32'd0);
`endif
        if (m_mode == M_RUN) tick(0, 0, 1);
        tick(1, 0, 0);
        repeat (10) tick(0, 0, 0);
        check_val("bp_hit_clear", {31'd0, bp_hit}, 32'd0);
        check_val("resumed", {31'd0, running}, 32'd1);
        tick(0, 0, 1);

        // halt in a due cycle, then reset mid-run
        bp_valid = 1'b0;
        tick(1, 0, 0);
        repeat (3) tick(0, 0, 0);
        tick(0, 0, 1);
        tick(0, 0, 0);
        tick(1, 0, 0);
        repeat (6) tick(0, 0, 0);
        async_reset();
        repeat (3) tick(0, 0, 0);

        // randomised pulses and breakpoint settings
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                bp_valid = 1'($urandom_range(0, 1));
                bp_addr  = 4'($urandom_range(0, 15));
            end
            tick($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 24) == 0);
        end

        // DIV=1: strobe every cycle and counter wrap
        run2 = 1'b1;
        @(posedge clk);
        #1 run2 = 1'b0;
        @(negedge clk);
        check_val("div1_first_en", {31'd0, cpu_en2}, 32'd1);
        check_val("div1_running", {31'd0, running2}, 32'd1);
        check_val("div1_count0", {16'd0, instr_count2}, 32'd0);
        repeat (65535) @(posedge clk);
        @(negedge clk);
        check_val("div1_count_max", {16'd0, instr_count2}, 32'h0000ffff);
        check_val("div1_en", {31'd0, cpu_en2}, 32'd1);
        @(negedge clk);
        check_val("div1_count_wrap", {16'd0, instr_count2}, 32'd0);
        check_val("div1_bp_hit", {31'd0, bp_hit2}, 32'd0);
        halt2 = 1'b1;
        @(negedge clk);
        halt2 = 1'b0;
        check_val("div1_halted", {31'd0, running2}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
